// File: rtl/audio_fetch_pkg.sv
// Shared types and helpers for the flash-backed audio sample fetcher.
package audio_fetch_pkg;

  localparam int SAMPLE_W_DEFAULT = 16;
  localparam int FLASH_WORD_W     = 2 * SAMPLE_W_DEFAULT;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_DATA,
    ST_OUT_FIRST,
    ST_WAIT_TICK2,
    ST_OUT_SECOND,
    ST_ADVANCE
  } fetch_state_t;

  // Step a word address one place in the playback direction, wrapping at 0 and last.
  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic fwd,
                                            input logic [31:0] last);
    logic [31:0] r;
    if (fwd) r = (addr >= last) ? 32'd0 : addr + 32'd1;
    else     r = (addr == 32'd0) ? last : addr - 32'd1;
    return r;
  endfunction

endpackage

// File: rtl/audio_sample_fetcher_tick_pending_tracker.sv
// Remembers one sample tick that arrives while the fetcher is busy; a second one is dropped
// and reported on overrun.
module tick_pending_tracker
  import audio_fetch_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic busy_tick,
  input  logic clear,
  output logic pending,
  output logic overrun
);

  logic pending_reg;
  logic overrun_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pending_reg <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      overrun_reg <= busy_tick & pending_reg;
      if (clear)          pending_reg <= 1'b0;
      else if (busy_tick) pending_reg <= 1'b1;
    end
  end

  assign pending = pending_reg;
  assign overrun = overrun_reg;

endmodule

// File: rtl/audio_sample_fetcher.sv
// Fetches 32-bit flash words over an Avalon-MM read master and plays out one 16-bit
// sample per accepted sample tick, with pause, direction and restart control.
module audio_sample_fetcher
  import audio_fetch_pkg::*;
#(
  parameter int                ADDR_W    = 23,
  parameter logic [ADDR_W-1:0] LAST_ADDR = 23'h7FFFF,
  parameter int                SAMPLE_W  = SAMPLE_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sample_tick,
  input  logic                  play,
  input  logic                  dir_fwd,
  input  logic                  restart,
  output logic                  flash_mem_read,
  output logic [ADDR_W-1:0]     flash_mem_address,
  input  logic                  flash_mem_waitrequest,
  input  logic [2*SAMPLE_W-1:0] flash_mem_readdata,
  input  logic                  flash_mem_readdatavalid,
  output logic [SAMPLE_W-1:0]   audio_out,
  output logic                  audio_valid,
  output logic                  overrun
);

  localparam int WORD_W = 2 * SAMPLE_W;

  fetch_state_t        state_reg, state_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [WORD_W-1:0]   word_reg;
  logic [SAMPLE_W-1:0] hold_reg;
  logic [SAMPLE_W-1:0] sample_sel;
  logic                half_sel_reg;
  logic                restart_pend_reg;

  logic pending;
  logic pend_clear;
  logic restart_apply;
  logic word_load;
  logic busy;
  logic restart_req;
  logic start_req;

  assign busy        = (state_reg != ST_IDLE) && (state_reg != ST_WAIT_TICK2);
  assign restart_req = restart | restart_pend_reg;
  assign start_req   = play & (sample_tick | pending);

  tick_pending_tracker u_tracker (
    .clk      (clk),
    .reset_n  (reset_n),
    .busy_tick(sample_tick & busy),
    .clear    (pend_clear),
    .pending  (pending),
    .overrun  (overrun)
  );

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    pend_clear    = 1'b0;
    restart_apply = 1'b0;
    word_load     = 1'b0;
    sample_sel    = hold_reg;
    case (state_reg)
      ST_IDLE: begin
        // Restart outranks a coincident tick, which is simply discarded.
        if (restart_req) begin
          restart_apply = 1'b1;
          pend_clear    = 1'b1;
          addr_next     = dir_fwd ? '0 : LAST_ADDR;
        end else if (start_req) begin
          pend_clear = 1'b1;
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        if (!flash_mem_waitrequest) state_next = ST_WAIT_DATA;
      end
      ST_WAIT_DATA: begin
        if (flash_mem_readdatavalid) begin
          word_load  = 1'b1;
          state_next = ST_OUT_FIRST;
        end
      end
      ST_OUT_FIRST: begin
        sample_sel = dir_fwd ? word_reg[SAMPLE_W-1:0] : word_reg[WORD_W-1:SAMPLE_W];
        state_next = ST_WAIT_TICK2;
      end
      ST_WAIT_TICK2: begin
        if (restart_req) begin
          restart_apply = 1'b1;
          pend_clear    = 1'b1;
          addr_next     = dir_fwd ? '0 : LAST_ADDR;
          state_next    = ST_IDLE;
        end else if (start_req) begin
          pend_clear = 1'b1;
          state_next = ST_OUT_SECOND;
        end
      end
      ST_OUT_SECOND: begin
        // The second half is always the one not played first, whatever dir_fwd is now.
        sample_sel = half_sel_reg ? word_reg[SAMPLE_W-1:0] : word_reg[WORD_W-1:SAMPLE_W];
        state_next = ST_ADVANCE;
      end
      ST_ADVANCE: begin
        addr_next  = ADDR_W'(next_addr(32'(addr_reg), dir_fwd, 32'(LAST_ADDR)));
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg        <= ST_IDLE;
      addr_reg         <= '0;
      word_reg         <= '0;
      hold_reg         <= '0;
      half_sel_reg     <= 1'b0;
      restart_pend_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      if (word_load) word_reg <= flash_mem_readdata;
      if (state_reg == ST_OUT_FIRST) half_sel_reg <= ~dir_fwd;
      if (audio_valid) hold_reg <= sample_sel;
      if (restart_apply) restart_pend_reg <= 1'b0;
      else if (restart)  restart_pend_reg <= 1'b1;
    end
  end

  assign flash_mem_read    = (state_reg == ST_REQ);
  assign flash_mem_address = addr_reg;
  assign audio_valid       = (state_reg == ST_OUT_FIRST) || (state_reg == ST_OUT_SECOND);
  assign audio_out         = sample_sel;

endmodule

// File: tb/tb_audio_sample_fetcher.sv
// Directed and randomized checks of audio_sample_fetcher against a flash slave model and a
// sample-stream reference.
module tb_audio_sample_fetcher;

  localparam logic [22:0] LAST   = 23'h7FFFF;
  localparam int          LAST_I = 'h7FFFF;

  logic        clk = 1'b0;
  logic        reset_n, sample_tick, play, dir_fwd, restart;
  logic        flash_mem_read, flash_mem_waitrequest, flash_mem_readdatavalid;
  logic [22:0] flash_mem_address;
  logic [31:0] flash_mem_readdata;
  logic [15:0] audio_out;
  logic        audio_valid, overrun;

  always #5 clk = ~clk;

  audio_sample_fetcher #(.ADDR_W(23), .LAST_ADDR(23'h7FFFF), .SAMPLE_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .sample_tick(sample_tick), .play(play),
    .dir_fwd(dir_fwd), .restart(restart),
    .flash_mem_read(flash_mem_read), .flash_mem_address(flash_mem_address),
    .flash_mem_waitrequest(flash_mem_waitrequest), .flash_mem_readdata(flash_mem_readdata),
    .flash_mem_readdatavalid(flash_mem_readdatavalid),
    .audio_out(audio_out), .audio_valid(audio_valid), .overrun(overrun)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [22:0] a);
    if (a == 23'd0) return 32'hBEEF_1234;
    return {a[15:0] ^ 16'hC3A5, a[15:0] + 16'h1111};
  endfunction

  // Flash slave: stall_left cycles of waitrequest, then data lat cycles after acceptance.
  int   stall_left = 0;
  int   lat = 2;
  bit   rand_mode = 0;
  int   cd = 0;
  logic [31:0] slave_word;

  initial begin
    bit acc, stalled;
    logic [22:0] acc_addr;
    flash_mem_waitrequest   = 1'b0;
    flash_mem_readdatavalid = 1'b0;
    flash_mem_readdata      = '0;
    forever begin
      @(negedge clk);
      acc      = flash_mem_read && !flash_mem_waitrequest;
      stalled  = flash_mem_read && flash_mem_waitrequest;
      acc_addr = flash_mem_address;
      @(posedge clk); #1;
      if (stalled && stall_left > 0) stall_left--;
      if (acc) begin
        slave_word = mem_word(acc_addr);
        cd = lat;
        if (rand_mode) begin
          stall_left = $urandom_range(0, 3);
          lat        = $urandom_range(1, 4);
        end
      end else if (cd > 0) begin
        cd--;
      end
      flash_mem_readdatavalid = (cd == 1);
      flash_mem_readdata      = (cd == 1) ? slave_word : 32'($urandom);
      flash_mem_waitrequest   = (stall_left > 0);
    end
  end

  // Observation side: every played sample, every accepted read and overrun pulses.
  int          cyc = 0;
  int          valid_cyc = 0, rdv_cyc = 0, ovr_cnt = 0;
  logic [15:0] obs_samples[$];
  logic [22:0] obs_addr[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (audio_valid) begin
      obs_samples.push_back(audio_out);
      valid_cyc = cyc;
    end
    if (overrun) ovr_cnt++;
    if (flash_mem_read && !flash_mem_waitrequest) obs_addr.push_back(flash_mem_address);
    if (flash_mem_readdatavalid) rdv_cyc = cyc;
  end

  // Reference: the word sequence and half order implied by direction, independent of timing.
  logic [22:0] m_addr;
  bit          m_half, m_fwd;
  logic [22:0] exp_addr[$];

  task automatic model_next(output logic [15:0] s);
    logic [31:0] w;
    if (!m_half) exp_addr.push_back(m_addr);
    w = mem_word(m_addr);
    if (!m_half) s = m_fwd ? w[15:0] : w[31:16];
    else         s = m_fwd ? w[31:16] : w[15:0];
    if (m_half) m_addr = 23'((int'(m_addr) + (m_fwd ? 1 : LAST_I)) % (LAST_I + 1));
    m_half = !m_half;
  endtask

  task automatic check_stream(input string tag);
    logic [15:0] s;
    int n;
    exp_addr.delete();
    for (int i = 0; i < obs_samples.size(); i++) begin
      model_next(s);
      check($sformatf("%s_sample%0d", tag, i), 32'(obs_samples[i]), 32'(s));
    end
    check({tag, "_nreads"}, obs_addr.size(), exp_addr.size());
    n = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_addr%0d", tag, i), 32'(obs_addr[i]), 32'(exp_addr[i]));
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick();
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
  endtask

  task automatic wait_samples(input int n, input int budget, input string tag);
    int k = 0;
    while (obs_samples.size() < n && k < budget) begin
      step(1);
      k++;
    end
    if (obs_samples.size() < n) check({tag, "_timeout"}, obs_samples.size(), n);
  endtask

  task automatic clear_obs();
    obs_samples.delete();
    obs_addr.delete();
  endtask

  initial begin
    logic [31:0] w;
    int rc, a0, ovr0, nticks;
    bit stable;
    reset_n = 1'b0; sample_tick = 1'b0; play = 1'b0; dir_fwd = 1'b1; restart = 1'b0;
    step(3);
    check("rst_read", flash_mem_read, 0);
    check("rst_addr", flash_mem_address, 0);
    check("rst_audio", audio_out, 0);
    check("rst_valid", audio_valid, 0);
    check("rst_overrun", overrun, 0);
    reset_n = 1'b1;
    step(2);

    // Forward basic: word 0, low half then high half.
    play = 1'b1; lat = 2; clear_obs();
    tick();
    check("t1_read_latency", flash_mem_read, 1);
    check("t1_read_addr", flash_mem_address, 0);
    wait_samples(1, 50, "t1a");
    check("t1_nreads", obs_addr.size(), 1);
    check("t1_addr0", obs_addr[0], 0);
    check("t1_first", obs_samples[0], 16'h1234);
    check("t1_valid_latency", valid_cyc, rdv_cyc + 1);
    step(3);
    tick();
    check("t1_tick2_valid", audio_valid, 1);
    wait_samples(2, 20, "t1b");
    check("t1_second", obs_samples[1], 16'hBEEF);
    step(4);
    check("t1_addr_after", flash_mem_address, 1);

    // Backward after restart: LAST word, high half first.
    dir_fwd = 1'b0; pulse_restart(); step(1);
    check("t2_restart_addr", flash_mem_address, 32'(LAST));
    clear_obs(); w = mem_word(LAST);
    tick(); wait_samples(1, 50, "t2a");
    check("t2_read_addr", obs_addr[0], 32'(LAST));
    check("t2_first_hi", obs_samples[0], w[31:16]);
    tick(); wait_samples(2, 20, "t2b");
    check("t2_second_lo", obs_samples[1], w[15:0]);
    step(4);
    check("t2_addr_after", flash_mem_address, 23'h7FFFE);

    // Forward wrap from LAST to 0.
    pulse_restart(); dir_fwd = 1'b1; step(1);
    clear_obs();
    tick(); wait_samples(1, 50, "t3a");
    tick(); wait_samples(2, 20, "t3b");
    step(4);
    check("t3_wrap_addr", flash_mem_address, 0);
    check("t3_lo", obs_samples[0], w[15:0]);
    check("t3_hi", obs_samples[1], w[31:16]);
    tick(); wait_samples(3, 50, "t3c");
    check("t3_nreads", obs_addr.size(), 2);
    check("t3_read_wrapped", obs_addr[1], 0);
    tick(); wait_samples(4, 20, "t3d");
    step(4);

    // waitrequest held for 5 cycles.
    clear_obs(); stall_left = 5;
    tick();
    rc = 0; a0 = flash_mem_address; stable = 1'b1;
    while (flash_mem_read && rc < 20) begin
      if (flash_mem_address !== 23'(a0)) stable = 1'b0;
      rc++;
      step(1);
    end
    check("t4_read_cycles", rc, 6);
    check("t4_addr_stable", stable, 1);
    check("t4_addr", a0, 1);
    wait_samples(1, 50, "t4a");
    check("t4_one_read", obs_addr.size(), 1);
    tick(); wait_samples(2, 20, "t4b");
    step(4);

    // Three ticks during a long read: one pends, two overrun.
    clear_obs(); lat = 10; ovr0 = ovr_cnt; w = mem_word(23'd2);
    tick(); step(2);
    tick(); step(1);
    tick(); step(1);
    tick();
    wait_samples(2, 40, "t5");
    step(6);
    check("t5_overruns", ovr_cnt - ovr0, 2);
    check("t5_nsamples", obs_samples.size(), 2);
    check("t5_lo", obs_samples[0], w[15:0]);
    check("t5_hi", obs_samples[1], w[31:16]);
    check("t5_addr_after", flash_mem_address, 3);
    lat = 2;

    // Paused ticks are ignored entirely.
    clear_obs(); play = 1'b0;
    tick(); step(20);
    check("t6_no_read", obs_addr.size(), 0);
    check("t6_no_sample", obs_samples.size(), 0);
    play = 1'b1; step(10);
    check("t6_no_pending", obs_addr.size(), 0);

    // Restart during a read: first half still plays, then jump to 0.
    clear_obs(); lat = 8; w = mem_word(23'd3);
    tick(); step(3);
    pulse_restart();
    wait_samples(1, 30, "t7");
    step(6);
    check("t7_first", obs_samples[0], w[15:0]);
    check("t7_nsamples", obs_samples.size(), 1);
    check("t7_addr_reset", flash_mem_address, 0);

    // Random fast ticks forward: stream must follow address order, drops are accounted.
    rand_mode = 1; dir_fwd = 1'b1; pulse_restart(); step(2);
    clear_obs(); ovr0 = ovr_cnt; nticks = 0;
    m_addr = 23'd0; m_half = 0; m_fwd = 1;
    for (int i = 0; i < 80; i++) begin
      tick(); nticks++;
      step($urandom_range(0, 5));
    end
    step(80);
    check("rf_accounted", (obs_samples.size() + ovr_cnt - ovr0 <= nticks), 1);
    check("rf_progress", (obs_samples.size() > 20), 1);
    check_stream("rf");

    // Random slow ticks backward: every tick yields exactly one sample.
    dir_fwd = 1'b0; pulse_restart(); step(3);
    clear_obs(); ovr0 = ovr_cnt; nticks = 0;
    m_addr = LAST; m_half = 0; m_fwd = 0;
    for (int i = 0; i < 20; i++) begin
      tick(); nticks++;
      step($urandom_range(20, 30));
    end
    step(40);
    check("rb_samples", obs_samples.size(), nticks);
    check("rb_no_overrun", ovr_cnt - ovr0, 0);
    check_stream("rb");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/audio_sample_fetcher.md
Name: audio_sample_fetcher

Overview:
- Consumer of the synchronized sample-rate pulse. That pulse is the 22 kHz tick brought into the 50 MHz domain, one clock wide.
- Each accepted tick presents one 16-bit signed audio sample to the audio codec path.
- Samples are fetched as 32-bit words from flash over an Avalon-MM-style read master, two samples per word.
- Supports play/pause, forward/backward playback and restart with address wrap.

Parameters:
ADDR_W, 23, flash word-address width
LAST_ADDR, 23'h7FFFF, final word address of the audio image
SAMPLE_W, 16, audio sample width; flash word is 2*SAMPLE_W

Ports:
clk  in  1  system clock (50 MHz)
reset_n  in  1  synchronous reset, active-low
sample_tick  in  1  one-cycle pulse from the synchronizer, already in the clk domain
play  in  1  1 = playback enabled, 0 = paused
dir_fwd  in  1  1 = forward, 0 = backward
restart  in  1  one-cycle request to jump to the start point for the current direction
flash_mem_read  out  1  read request
flash_mem_address  out  ADDR_W  word address
flash_mem_waitrequest  in  1  slave stall
flash_mem_readdata  in  2*SAMPLE_W  read data
flash_mem_readdatavalid  in  1  read data qualifier
audio_out  out  SAMPLE_W  current sample, held between updates
audio_valid  out  1  one-cycle pulse on each audio_out update
overrun  out  1  one-cycle pulse when a tick is dropped

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - State IDLE, address 0, half-select 0, pending-tick flag 0, pending-restart flag 0.
  - All outputs 0.
- States: IDLE, REQ, WAIT_DATA, OUT_FIRST, WAIT_TICK2, OUT_SECOND, ADVANCE.
- IDLE:
  - On sample_tick&play, or pending&play, go to REQ. Clear pending.
  - Ticks with play=0 are ignored and do not set pending.
- REQ: flash_mem_read=1, address stable. Hold until flash_mem_waitrequest=0, then go to WAIT_DATA.
- WAIT_DATA: on flash_mem_readdatavalid, latch the word, then go to OUT_FIRST.
- OUT_FIRST:
  - audio_out takes the first half: forward = bits[15:0], backward = bits[31:16].
  - audio_valid=1 for this cycle. Then go to WAIT_TICK2.
- WAIT_TICK2: on sample_tick&play, or pending&play, go to OUT_SECOND. Clear pending.
- OUT_SECOND: audio_out takes the other half, audio_valid=1, then go to ADVANCE.
- ADVANCE:
  - Forward: address+1, with LAST_ADDR wrapping to 0.
  - Backward: address-1, with 0 wrapping to LAST_ADDR.
  - Then go to IDLE.
- Latency:
  - Tick accepted in IDLE at edge n: flash_mem_read=1 from cycle n+1.
  - readdatavalid at edge m: audio_valid at cycle m+1.
  - Tick accepted in WAIT_TICK2 at edge k: audio_valid at cycle k+1.
- Ticks while busy (states REQ, WAIT_DATA, OUT_FIRST, OUT_SECOND, ADVANCE):
  - If pending=0, set pending.
  - If pending=1, drop the tick and pulse overrun.
- Restart:
  - Sets pending-restart.
  - The flag is applied only in IDLE or WAIT_TICK2, never during an outstanding read, because Avalon requires read to stay held until accepted and the data to be consumed.
  - On apply: address becomes 0 if dir_fwd else LAST_ADDR. Pending tick clears. State goes to IDLE. No audio_valid.
  - If restart and a tick coincide in IDLE/WAIT_TICK2, restart wins and the tick is discarded.
- dir_fwd:
  - Sampled in OUT_FIRST, OUT_SECOND, ADVANCE and at restart apply.
  - Changing it mid-word affects only the remaining half ordering from the next word.
- Pause (play=0):
  - Completes any outstanding read and OUT_FIRST, then stalls in IDLE or WAIT_TICK2.
  - audio_out holds its last value.
- readdatavalid outside WAIT_DATA is ignored.
- Address arithmetic is modulo the LAST_ADDR range. The address never exceeds LAST_ADDR.

Decomposition:
- Package audio_fetch_pkg holds:
  - state enum fetch_state_t
  - SAMPLE_W default
  - FLASH_WORD_W = 2*SAMPLE_W
  - helper function next_addr(addr, fwd, last) implementing the wrap rules
- One sub-module, tick_pending_tracker, owns the pending-tick flag and the overrun pulse. It has a clear input driven by the FSM.

Test Plan:
- Reset, play=1, dir_fwd=1, tick; slave returns 32'hBEEF_1234 with waitrequest=0 and 2-cycle data latency:
  - address 0 read.
  - audio_out=16'h1234 with audio_valid.
  - Next tick gives 16'hBEEF.
  - Address then becomes 1.
- Backward from address 0 after restart with dir_fwd=0:
  - Reads LAST_ADDR (23'h7FFFF).
  - High half emitted first.
  - After the second tick, address becomes 23'h7FFFE.
- Forward wrap: force address to LAST_ADDR and play two ticks -> next read is at address 0.
- waitrequest held high 5 cycles -> flash_mem_read and address stay stable for 6 cycles, and exactly one read is issued.
- Three ticks during a 10-cycle WAIT_DATA:
  - First tick sets pending.
  - Second and third ticks each pulse overrun.
  - After OUT_FIRST, OUT_SECOND follows without a new tick.
- play=0 then tick -> no read and no audio_valid.
- restart asserted during WAIT_DATA -> word still emitted as OUT_FIRST, then at WAIT_TICK2 the address resets to 0 with no second-half output.
